// File: rtl/data_mem_resp.sv
// Shared request/response types and a fixed-latency data memory responder.
// One access is in flight at a time and all outputs are registered.
package sys;
  typedef logic bool_t;

  typedef struct packed {
    logic        en;
    logic [31:0] addr;
    logic [2:0]  size;
  } mem_read_req_t;

  typedef struct packed {
    logic        en;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] data;
  } mem_write_req_t;

  typedef struct packed {
    logic        done;
    logic [31:0] data;
  } mem_read_rsp_t;

  typedef struct packed {
    logic done;
  } mem_write_rsp_t;
endpackage

module data_mem_resp #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned LATENCY     = 2
) (
  input  logic               clk,
  input  sys::bool_t         rst,
  input  sys::mem_read_req_t  mem_read_req,
  input  sys::mem_write_req_t mem_write_req,
  output sys::mem_read_rsp_t  mem_read_rsp,
  output sys::mem_write_rsp_t mem_write_rsp,
  output sys::bool_t         err
);
  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        is_wr_q, wr_pend_q;
  logic [31:0] addr_q, data_q;
  logic [2:0]  size_q;
  logic        rd_done_q, wr_done_q, err_q;
  logic [31:0] rd_data_q;
  logic [31:0] mem_q [DEPTH_WORDS];

  function automatic logic [31:0] size_mask(input logic [2:0] size);
    case (size)
      3'd1:    return 32'h0000_00FF;
      3'd2:    return 32'h0000_FFFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [1:0] lane,
                                               input logic [2:0] size);
    return (word >> {lane, 3'b000}) & size_mask(size);
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] old, input logic [31:0] wdata,
                                             input logic [1:0] lane, input logic [2:0] size);
    logic [31:0] m;
    m = size_mask(size) << {lane, 3'b000};
    return (old & ~m) | ((wdata << {lane, 3'b000}) & m);
  endfunction

  logic          take_rd, take_wr, req_take, enter_done, mem_we, bad;
  logic          op_is_wr;
  logic [31:0]   op_addr, op_data, eff, rd_word, rd_data_d, wr_word_d;
  logic [2:0]    op_size;
  logic [29:0]   word_off;
  logic [AW-1:0] idx;
  logic [1:0]    lane;

  // A write that lost arbitration to a read gets the next IDLE slot.
  always_comb begin
    take_wr  = mem_write_req.en && (wr_pend_q || !mem_read_req.en);
    take_rd  = mem_read_req.en && !take_wr;
    req_take = take_rd || take_wr;
  end

  // Operands come straight from the ports when completing in the capture cycle.
  always_comb begin
    op_is_wr = is_wr_q;
    op_addr  = addr_q;
    op_size  = size_q;
    op_data  = data_q;
    if (state_q == IDLE) begin
      op_is_wr = take_wr;
      op_addr  = take_wr ? mem_write_req.addr : mem_read_req.addr;
      op_size  = take_wr ? mem_write_req.size : mem_read_req.size;
      op_data  = mem_write_req.data;
    end
  end

  always_comb begin
    eff = op_addr;
    case (op_size)
      3'd2:    eff = {op_addr[31:1], 1'b0};
      3'd4:    eff = {op_addr[31:2], 2'b00};
      default: eff = op_addr;
    endcase
    word_off  = eff[31:2] - BASE_ADDR[31:2];
    idx       = word_off[AW-1:0];
    lane      = eff[1:0];
    bad       = !(op_size inside {3'd1, 3'd2, 3'd4}) || (eff < BASE_ADDR) ||
                ({2'b00, word_off} >= DEPTH_WORDS);
    rd_word   = mem_q[idx];
    rd_data_d = bad ? 32'h0 : lane_extract(rd_word, lane, op_size);
    wr_word_d = lane_merge(rd_word, op_data, lane, op_size);
    enter_done = ((state_q == IDLE) && req_take && (LATENCY == 1)) ||
                 ((state_q == BUSY) && (cnt_q == 4'd1));
    mem_we    = enter_done && op_is_wr && !bad && !rst;
  end

  // Backing array is never reset; contents come from writes or preload.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[idx] <= wr_word_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      wr_pend_q <= 1'b0;
      rd_done_q <= 1'b0;
      wr_done_q <= 1'b0;
      err_q     <= 1'b0;
      rd_data_q <= 32'h0;
    end else begin
      rd_done_q <= 1'b0;
      wr_done_q <= 1'b0;
      err_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          wr_pend_q <= take_rd && mem_write_req.en;
          if (req_take) begin
            is_wr_q <= take_wr;
            addr_q  <= op_addr;
            size_q  <= op_size;
            data_q  <= op_data;
            if (LATENCY == 1) begin
              state_q <= DONE;
            end else begin
              state_q <= BUSY;
              cnt_q   <= 4'(LATENCY - 1);
            end
          end
        end
        BUSY: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_q <= DONE;
        end
        default: state_q <= IDLE;
      endcase
      if (enter_done) begin
        rd_done_q <= !op_is_wr;
        wr_done_q <= op_is_wr;
        err_q     <= bad;
        if (!op_is_wr) rd_data_q <= rd_data_d;
      end
    end
  end

  assign mem_read_rsp.done  = rd_done_q;
  assign mem_read_rsp.data  = rd_data_q;
  assign mem_write_rsp.done = wr_done_q;
  assign err                = err_q;
endmodule

// File: tb/tb_data_mem_resp.sv
// Directed bench for data_mem_resp: expectations are queued at issue time and
// checked, including completion cycle, when each done pulse appears.
module tb_data_mem_resp;
  localparam int LAT = 2;

  typedef struct {
    bit          is_wr;
    logic [31:0] data;
    bit          err;
    int          due;
    string       tag;
  } exp_t;

  logic                clk = 1'b0;
  sys::bool_t          rst;
  sys::mem_read_req_t  rd_req;
  sys::mem_write_req_t wr_req;
  sys::mem_read_rsp_t  rd_rsp;
  sys::mem_write_rsp_t wr_rsp;
  sys::bool_t          err;

  exp_t        sb[$];
  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;
  logic        rst_seen = 1'b1;
  logic [31:0] last_rd = 32'h0;

  data_mem_resp #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .mem_read_req(rd_req), .mem_write_req(wr_req),
    .mem_read_rsp(rd_rsp), .mem_write_rsp(wr_rsp), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Output monitor: pops the scoreboard on every done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (rst_seen) last_rd = 32'h0;
    if (rd_rsp.done || wr_rsp.done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", {30'b0, rd_rsp.done, wr_rsp.done}, 32'h0);
        if (rd_rsp.done) last_rd = rd_rsp.data;
      end else begin
        e = sb.pop_front();
        chk({e.tag, "_wrdone"}, {31'b0, wr_rsp.done}, {31'b0, e.is_wr});
        chk({e.tag, "_rddone"}, {31'b0, rd_rsp.done}, {31'b0, !e.is_wr});
        chk({e.tag, "_cycle"}, cyc, e.due);
        chk({e.tag, "_err"}, {31'b0, err}, {31'b0, e.err});
        if (!e.is_wr) begin
          chk({e.tag, "_data"}, rd_rsp.data, e.data);
          last_rd = e.data;
        end
      end
    end else begin
      chk("idle_err", {31'b0, err}, 32'h0);
      chk("hold_data", rd_rsp.data, last_rd);
    end
  end

  task automatic push(input bit is_wr, input logic [31:0] d, input bit e, input int due,
                      input string tag);
    exp_t x;
    x.is_wr = is_wr; x.data = d; x.err = e; x.due = due; x.tag = tag;
    sb.push_back(x);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    chk("drain_timeout", sb.size(), 32'd0);
    sb.delete();
    @(negedge clk);
  endtask

  task automatic do_rd(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] exp,
                       input bit experr, input string tag);
    @(negedge clk);
    rd_req = '{en: 1'b1, addr: a, size: sz};
    push(1'b0, exp, experr, cyc + LAT, tag);
    @(negedge clk);
    rd_req.en = 1'b0;
    drain();
  endtask

  task automatic do_wr(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d,
                       input bit experr, input string tag);
    @(negedge clk);
    wr_req = '{en: 1'b1, addr: a, size: sz, data: d};
    push(1'b1, 32'h0, experr, cyc + LAT, tag);
    @(negedge clk);
    wr_req.en = 1'b0;
    drain();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    rst    = 1'b1;
    rd_req = '{en: 1'b0, addr: 32'h0, size: 3'd4};
    wr_req = '{en: 1'b0, addr: 32'h0, size: 3'd4, data: 32'h0};
    repeat (3) @(negedge clk);
    chk("rst_rd_done", {31'b0, rd_rsp.done}, 32'h0);
    chk("rst_rd_data", rd_rsp.data, 32'h0);
    chk("rst_wr_done", {31'b0, wr_rsp.done}, 32'h0);
    chk("rst_err", {31'b0, err}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Basic word write then read back
    do_wr(32'h10, 3'd4, 32'hDEADBEEF, 1'b0, "sw10");
    do_rd(32'h10, 3'd4, 32'hDEADBEEF, 1'b0, "lw10");

    // Sub-word lanes
    do_wr(32'h10, 3'd4, 32'h11223344, 1'b0, "sw10b");
    do_rd(32'h13, 3'd1, 32'h00000011, 1'b0, "lb13");
    do_rd(32'h12, 3'd2, 32'h00001122, 1'b0, "lh12");
    do_rd(32'h13, 3'd2, 32'h00001122, 1'b0, "lh13_align");
    do_rd(32'h10, 3'd1, 32'h00000044, 1'b0, "lb10");
    do_wr(32'h11, 3'd1, 32'hFFFFFFAB, 1'b0, "sb11");
    do_rd(32'h10, 3'd4, 32'h1122AB44, 1'b0, "lw10_sb");

    // Back-to-back reads with read held across DONE
    do_wr(32'h0, 3'd4, 32'hA5A50001, 1'b0, "sw0");
    do_wr(32'h4, 3'd4, 32'h5A5A0002, 1'b0, "sw4");
    @(negedge clk);
    c = cyc;
    rd_req = '{en: 1'b1, addr: 32'h0, size: 3'd4};
    push(1'b0, 32'hA5A50001, 1'b0, c + LAT, "b2b_lw0");
    push(1'b0, 32'h5A5A0002, 1'b0, c + 2 * LAT + 1, "b2b_lw4");
    @(negedge clk);
    rd_req.addr = 32'h4;
    repeat (3) @(negedge clk);
    rd_req.en = 1'b0;
    drain();

    // Read and write together: read first with pre-write data
    @(negedge clk);
    c = cyc;
    rd_req = '{en: 1'b1, addr: 32'h10, size: 3'd4};
    wr_req = '{en: 1'b1, addr: 32'h10, size: 3'd4, data: 32'hCAFEF00D};
    push(1'b0, 32'h1122AB44, 1'b0, c + LAT, "both_rd");
    push(1'b1, 32'h0, 1'b0, c + 2 * LAT + 1, "both_wr");
    repeat (4) @(negedge clk);
    rd_req.en = 1'b0;
    wr_req.en = 1'b0;
    drain();
    do_rd(32'h10, 3'd4, 32'hCAFEF00D, 1'b0, "lw10_post");

    // Out-of-range and illegal sizes
    do_rd(32'h1000, 3'd4, 32'h0, 1'b1, "lw_oob");
    do_wr(32'h1000, 3'd4, 32'h12345678, 1'b1, "sw_oob");
    do_rd(32'h0, 3'd4, 32'hA5A50001, 1'b0, "lw0_after_oob");
    do_rd(32'h10, 3'd3, 32'h0, 1'b1, "lw_size3");
    do_wr(32'h10, 3'd0, 32'h0BADBAD0, 1'b1, "sw_size0");
    do_rd(32'h10, 3'd4, 32'hCAFEF00D, 1'b0, "lw10_after_bad");
    do_rd(32'h0, 3'd2, 32'h00000001, 1'b0, "lh0");
    do_rd(32'h3, 3'd1, 32'h000000A5, 1'b0, "lb3");

    // Reset during BUSY aborts a write
    @(negedge clk);
    wr_req = '{en: 1'b1, addr: 32'h4, size: 3'd4, data: 32'hFFFF0000};
    @(negedge clk);
    wr_req.en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("abort_rd_done", {31'b0, rd_rsp.done}, 32'h0);
    chk("abort_rd_data", rd_rsp.data, 32'h0);
    chk("abort_wr_done", {31'b0, wr_rsp.done}, 32'h0);
    chk("abort_err", {31'b0, err}, 32'h0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    do_rd(32'h4, 3'd4, 32'h5A5A0002, 1'b0, "lw4_after_abort");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
